// File: rtl/bcd_field_scanner.sv
// bcd_field_scanner: frame-synchronous snapshot and valid/ready streamer of packed two-digit BCD fields
//   Optional macro BCD_CHECK_EN: maps non-BCD nibbles to 4'hF and adds bcd_err.
//   Ports: clk, reset (async active-low), frame_start pulse, fields (NUM_FIELDS x 8 bit BCD),
//          cursor_en/cursor_sel (blink target), out_valid/out_ready handshake, out_sel/out_dec/out_uni beat,
//          out_blank (cursor blink), out_last (final field), busy, overrun (frame_start while busy)
module bcd_field_scanner #(
  parameter int NUM_FIELDS   = 9,
  parameter int SEL_W        = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic [NUM_FIELDS*8-1:0] fields,
  input  logic                    cursor_en,
  input  logic [SEL_W-1:0]        cursor_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel,
  output logic [3:0]              out_dec,
  output logic [3:0]              out_uni,
  output logic                    out_blank,
  output logic                    out_last,
  output logic                    busy,
`ifdef BCD_CHECK_EN
  output logic                    bcd_err,
`endif
  output logic                    overrun
);
  localparam int CW = $clog2(BLINK_FRAMES + 1);
  localparam logic [1:0] IDLE = 2'd0, SNAP = 2'd1, SCAN = 2'd2;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_FIELDS - 1);
  localparam logic [CW-1:0] BLINK_MAX = CW'(BLINK_FRAMES - 1);
  logic [1:0] state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [7:0] snap_q [NUM_FIELDS];
  logic [7:0] cur;
  logic pending_q, pending_d, overrun_q, phase_q, phase_d;
  logic [CW-1:0] blink_q, blink_d;
  logic accept, last_acc, go_snap;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == SCAN;
  assign out_sel   = idx_q;
  assign out_last  = out_valid && idx_q == LAST;
  assign overrun   = overrun_q;
  assign cur       = snap_q[idx_q];
  // idx_q never leaves 0..NUM_FIELDS-1, so an out-of-range cursor_sel can never match
  assign out_blank = cursor_en && cursor_sel == idx_q && phase_q;
`ifdef BCD_CHECK_EN
  assign out_dec = cur[7:4] > 4'd9 ? 4'hF : cur[7:4];
  assign out_uni = cur[3:0] > 4'd9 ? 4'hF : cur[3:0];
  assign bcd_err = out_valid && (cur[7:4] > 4'd9 || cur[3:0] > 4'd9);
`else
  assign out_dec = cur[7:4];
  assign out_uni = cur[3:0];
`endif
  always_comb begin
    accept    = out_valid && out_ready;
    last_acc  = accept && idx_q == LAST;
    // a frame pulse coinciding with the final accept is served like a pending one
    go_snap   = (state_q == IDLE && frame_start) || (last_acc && (pending_q || frame_start));
    state_d   = go_snap ? SNAP : state_q == SNAP ? SCAN : last_acc ? IDLE : state_q;
    idx_d     = go_snap ? '0 : (accept && !last_acc) ? idx_q + 1'b1 : idx_q;
    pending_d = !go_snap && (pending_q || (frame_start && busy));
    blink_d   = !frame_start ? blink_q : blink_q == BLINK_MAX ? '0 : blink_q + 1'b1;
    phase_d   = phase_q ^ (frame_start && blink_q == BLINK_MAX);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      blink_q   <= '0;
      phase_q   <= 1'b0;
      for (int k = 0; k < NUM_FIELDS; k++) snap_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_q <= frame_start && busy;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      if (go_snap)
        for (int k = 0; k < NUM_FIELDS; k++) snap_q[k] <= fields[8*k +: 8];
    end
  end
endmodule

// File: tb/tb_bcd_field_scanner.sv
// tb_bcd_field_scanner: directed self-checking bench for bcd_field_scanner
module tb_bcd_field_scanner;
  localparam int NF = 9, SW = 4, BF = 2;
  logic clk = 1'b0, reset = 1'b0, frame_start = 1'b0, cursor_en = 1'b0, out_ready = 1'b1;
  logic [NF*8-1:0] fields = '0;
  logic [SW-1:0] cursor_sel = '0;
  logic out_valid, out_blank, out_last, busy, overrun;
  logic [SW-1:0] out_sel;
  logic [3:0] out_dec, out_uni;
`ifdef BCD_CHECK_EN
  logic bcd_err;
`endif
  int nvec = 0, nerr = 0, nframes = 0;
  logic [7:0] exp_f [NF];
  bcd_field_scanner #(.NUM_FIELDS(NF), .SEL_W(SW), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .fields(fields),
    .cursor_en(cursor_en), .cursor_sel(cursor_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_dec(out_dec), .out_uni(out_uni), .out_blank(out_blank),
    .out_last(out_last), .busy(busy),
`ifdef BCD_CHECK_EN
    .bcd_err(bcd_err),
`endif
    .overrun(overrun));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_fields();
    for (int k = 0; k < NF; k++) fields[8*k +: 8] = exp_f[k];
  endtask
  task automatic pulse_fs();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    nframes++;
  endtask
  task automatic scan_chk(input string tag);
    logic [3:0] ed, eu;
    logic ph;
    pulse_fs();
    ph = ((nframes / BF) % 2) == 1;
    @(negedge clk);
    chk({tag, "_snap_valid"}, out_valid, 0);
    chk({tag, "_snap_busy"}, busy, 1);
    for (int i = 0; i < NF; i++) begin
      @(negedge clk);
      ed = exp_f[i][7:4];
      eu = exp_f[i][3:0];
`ifdef BCD_CHECK_EN
      chk($sformatf("%s_err%0d", tag, i), bcd_err, ed > 9 || eu > 9);
      if (ed > 9) ed = 4'hF;
      if (eu > 9) eu = 4'hF;
`endif
      chk($sformatf("%s_valid%0d", tag, i), out_valid, 1);
      chk($sformatf("%s_sel%0d", tag, i), out_sel, i);
      chk($sformatf("%s_dec%0d", tag, i), out_dec, ed);
      chk($sformatf("%s_uni%0d", tag, i), out_uni, eu);
      chk($sformatf("%s_last%0d", tag, i), out_last, i == NF - 1);
      chk($sformatf("%s_blank%0d", tag, i), out_blank, cursor_en && cursor_sel == i && ph);
    end
    @(negedge clk);
    chk({tag, "_end_valid"}, out_valid, 0);
    chk({tag, "_end_busy"}, busy, 0);
  endtask
  initial begin
    int idx, ov_cnt, beats;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", out_sel, 0);
    chk("rst_dec", out_dec, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk); reset = 1'b1;
    // basic scan, fields k = 8'hkk
    for (int k = 0; k < NF; k++) exp_f[k] = {4'(k), 4'(k)};
    set_fields();
    scan_chk("t2");
    // stalls plus fields changing under the scan
    for (int k = 0; k < NF; k++) exp_f[k] = {4'(9 - k), 4'(k)};
    set_fields();
    pulse_fs();
    @(negedge clk);
    idx = 0;
    for (int c = 0; c < 40 && idx < NF; c++) begin
      @(negedge clk);
      chk("t3_valid", out_valid, 1);
      chk("t3_sel", out_sel, idx);
      chk("t3_dec", out_dec, exp_f[idx][7:4]);
      chk("t3_uni", out_uni, exp_f[idx][3:0]);
      if (out_ready) idx++;
      @(posedge clk); #1;
      out_ready = ~out_ready;
      fields = ~fields;
    end
    chk("t3_done", idx, NF);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_idle", out_valid, 0);
    // two frame pulses during a scan: two overruns, one extra back-to-back scan
    pulse_fs();
    ov_cnt = 0;
    beats = 0;
    for (int c = 1; c <= 21; c++) begin
      frame_start = (c == 3 || c == 6);
      @(negedge clk);
      ov_cnt += int'(overrun);
      beats += int'(out_valid);
      if (c == 4 || c == 7) chk($sformatf("t4_ovr%0d", c), overrun, 1);
      if (c == 11) begin
        chk("t4_gap_valid", out_valid, 0);
        chk("t4_gap_busy", busy, 1);
      end
      if (c == 12) chk("t4_rescan_sel", out_sel, 0);
      if (c == 21) chk("t4_idle_busy", busy, 0);
      @(posedge clk); #1;
    end
    frame_start = 1'b0;
    nframes += 2;
    chk("t4_ovr_count", ov_cnt, 2);
    chk("t4_beats", beats, 2 * NF);
    // non-BCD nibbles
    for (int k = 0; k < NF; k++) exp_f[k] = {4'(k), 4'(k)};
    exp_f[2] = 8'hA5;
    exp_f[5] = 8'h3C;
    set_fields();
    scan_chk("t6");
    // reset in the middle of a scan
    pulse_fs();
    repeat (3) @(negedge clk);
    chk("t1_pre_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("t1_valid", out_valid, 0);
    chk("t1_busy", busy, 0);
    chk("t1_sel", out_sel, 0);
    chk("t1_dec", out_dec, 0);
    chk("t1_uni", out_uni, 0);
    chk("t1_last", out_last, 0);
    chk("t1_blank", out_blank, 0);
    chk("t1_overrun", overrun, 0);
    @(negedge clk); reset = 1'b1;
    nframes = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t1_post_valid", out_valid, 0);
      chk("t1_post_busy", busy, 0);
    end
    // cursor blink, phase toggles every BF frames; out-of-range cursor never blanks
    cursor_en = 1'b1;
    for (int f = 1; f <= 6; f++) begin
      cursor_sel = (f == 6) ? SW'(9) : SW'(3);
      scan_chk($sformatf("t5f%0d", f));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
